// File: rtl/gfc_pkg.sv
// Shared types and helpers for the grayscale frame controller.
// The BMP row-pad helper is used only when GFC_ROW_PAD_EN is defined.
package gfc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Source bytes arrive in BMP order: blue, green, red.
    localparam logic [1:0] LANE_B = 2'd0;
    localparam logic [1:0] LANE_G = 2'd1;
    localparam logic [1:0] LANE_R = 2'd2;

    // Row/column counters hold up to 4095; pixel counters up to 4095*4095.
    localparam int DIM_W = 12;
    localparam int CNT_W = 24;

    function automatic int row_pad(input int img_w);
        return (4 - ((3 * img_w) % 4)) % 4;
    endfunction

endpackage

// File: rtl/pixel_byte_packer.sv
// Assembles three returned source bytes (B, G, R) into one pixel strobe.
// The red byte is forwarded straight from the read bus so the pixel leaves on its return cycle.
module pixel_byte_packer
    import gfc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rd,
    input  logic [1:0] lane,
    input  logic [7:0] data,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       pix_valid
);

    logic       rd_q;
    logic [1:0] lane_q;
    logic [7:0] blue_q;
    logic [7:0] green_q;

    // NOTE: non-blocking assignments keep every register reading pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= 1'b0;
            lane_q  <= LANE_B;
            blue_q  <= 8'h00;
            green_q <= 8'h00;
        end else begin
            rd_q   <= rd;
            lane_q <= lane;
            if (rd_q && (lane_q == LANE_B)) blue_q  <= data;
            if (rd_q && (lane_q == LANE_G)) green_q <= data;
        end
    end

    assign pix_valid = !rst && rd_q && (lane_q == LANE_R);
    assign red       = pix_valid ? data    : 8'h00;
    assign green     = pix_valid ? green_q : 8'h00;
    assign blue      = pix_valid ? blue_q  : 8'h00;

endmodule

// File: rtl/grayscale_frame_ctrl.sv
// Frame sequencer: streams a BGR frame from source memory to a converter and writes results back.
// Define GFC_ROW_PAD_EN to skip BMP 4-byte row padding in the source address stream.
module grayscale_frame_ctrl
    import gfc_pkg::*;
#(
    parameter int IMG_W    = 128,
    parameter int IMG_H    = 128,
    parameter int SRC_BASE = 54,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              src_rd_o,
    output logic [ADDR_W-1:0] src_addr_o,
    input  logic [7:0]        src_data_i,
    output logic [7:0]        red_o,
    output logic [7:0]        green_o,
    output logic [7:0]        blue_o,
    output logic              pix_valid_o,
    input  logic [7:0]        gray_i,
    input  logic              gray_valid_i,
    output logic              dst_we_o,
    output logic [ADDR_W-1:0] dst_addr_o,
    output logic [7:0]        dst_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [CNT_W-1:0] TOTAL    = CNT_W'(IMG_W * IMG_H);
    localparam logic [DIM_W-1:0] LAST_COL = DIM_W'(IMG_W - 1);
    localparam logic [DIM_W-1:0] LAST_ROW = DIM_W'(IMG_H - 1);
`ifdef GFC_ROW_PAD_EN
    localparam int PAD = row_pad(IMG_W);
`else
    localparam int PAD = 0;
`endif
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(1 + PAD);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] src_addr;
    logic [1:0]        lane;
    logic [DIM_W-1:0]  col;
    logic [DIM_W-1:0]  row;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  wr_cnt;
    logic [CNT_W-1:0]  wr_cnt_nxt;
    logic              err;
    logic              run;
    logic              in_frame;
    logic              accept;
    logic              row_end;
    logic              last_byte;
    logic              load;

    assign run       = !rst;
    assign in_frame  = (state == READ) || (state == DRAIN);
    assign accept    = run && in_frame && gray_valid_i && (wr_cnt < TOTAL);
    assign row_end   = (lane == LANE_R) && (col == LAST_COL);
    assign last_byte = row_end && (row == LAST_ROW);
    assign load      = (state == IDLE) && start_i;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt  = state;
        wr_cnt_nxt = accept ? (wr_cnt + CNT_W'(1)) : wr_cnt;
        case (state)
            IDLE:    if (start_i) state_nxt = READ;
            READ:    if (last_byte) state_nxt = DRAIN;
            // In DRAIN every pixel has been read; finish once writes catch up.
            DRAIN:   if (wr_cnt_nxt == rd_cnt) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            src_addr <= '0;
            lane     <= LANE_B;
            col      <= '0;
            row      <= '0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            err      <= 1'b0;
        end else begin
            state  <= state_nxt;
            wr_cnt <= wr_cnt_nxt;
            if (load) begin
                src_addr <= ADDR_W'(SRC_BASE);
                lane     <= LANE_B;
                col      <= '0;
                row      <= '0;
                rd_cnt   <= '0;
                wr_cnt   <= '0;
                err      <= 1'b0;
            end else if (state == READ) begin
                src_addr <= src_addr + (row_end ? ROW_STEP : ADDR_W'(1));
                if (lane == LANE_R) begin
                    lane   <= LANE_B;
                    rd_cnt <= rd_cnt + CNT_W'(1);
                    if (col == LAST_COL) begin
                        col <= '0;
                        row <= row + DIM_W'(1);
                    end else begin
                        col <= col + DIM_W'(1);
                    end
                end else begin
                    lane <= lane + 2'd1;
                end
            end
            // A stray result wins over the clear done by a coincident start.
            if (gray_valid_i && !accept) err <= 1'b1;
        end
    end

    pixel_byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .rd        (state == READ),
        .lane      (lane),
        .data      (src_data_i),
        .red       (red_o),
        .green     (green_o),
        .blue      (blue_o),
        .pix_valid (pix_valid_o)
    );

    assign src_rd_o   = run && (state == READ);
    assign src_addr_o = run ? src_addr : '0;
    assign dst_we_o   = accept;
    assign dst_addr_o = accept ? ADDR_W'(wr_cnt) : '0;
    assign dst_data_o = accept ? gray_i : 8'h00;
    assign busy_o     = run && in_frame;
    assign done_o     = run && (state == DONE);
    assign err_o      = run && err;

endmodule

// File: tb/tb_grayscale_frame_ctrl.sv
// Scoreboard bench for grayscale_frame_ctrl: random image bytes, variable-latency converter model.
// A second 5x2 instance checks the source address stream across the row boundary.
`timescale 1ns/1ps
module tb_grayscale_frame_ctrl;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int BASE = 54;
    localparam int NPIX = W * H;
    localparam int PW   = 5;
    localparam int PH   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, inj_valid, conv_valid;
    logic        src_rd, pix_valid, dst_we, busy, done, err;
    logic [15:0] src_addr, dst_addr;
    logic [7:0]  src_data, red, green, blue, gray, dst_data;
    wire         gray_valid = conv_valid | inj_valid;

    logic        rst_p, start_p, p_rd, p_pv, p_we, p_busy, p_done, p_err;
    logic [15:0] p_addr, p_daddr;
    logic [7:0]  p_r, p_g, p_b, p_ddata;

    grayscale_frame_ctrl #(.IMG_W(W), .IMG_H(H), .SRC_BASE(BASE), .ADDR_W(16)) u_dut (
        .clk(clk), .rst(rst), .start_i(start),
        .src_rd_o(src_rd), .src_addr_o(src_addr), .src_data_i(src_data),
        .red_o(red), .green_o(green), .blue_o(blue), .pix_valid_o(pix_valid),
        .gray_i(gray), .gray_valid_i(gray_valid),
        .dst_we_o(dst_we), .dst_addr_o(dst_addr), .dst_data_o(dst_data),
        .busy_o(busy), .done_o(done), .err_o(err)
    );

    grayscale_frame_ctrl #(.IMG_W(PW), .IMG_H(PH), .SRC_BASE(BASE), .ADDR_W(16)) u_pad (
        .clk(clk), .rst(rst_p), .start_i(start_p),
        .src_rd_o(p_rd), .src_addr_o(p_addr), .src_data_i(8'h00),
        .red_o(p_r), .green_o(p_g), .blue_o(p_b), .pix_valid_o(p_pv),
        .gray_i(8'h00), .gray_valid_i(1'b0),
        .dst_we_o(p_we), .dst_addr_o(p_daddr), .dst_data_o(p_ddata),
        .busy_o(p_busy), .done_o(p_done), .err_o(p_err)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // Reference behaviour: a BMP row occupies 3*W bytes, optionally padded to 4-byte alignment.
    function automatic int pad_bytes(input int w);
`ifdef GFC_ROW_PAD_EN
        return (4 - ((3 * w) % 4)) % 4;
`else
        return 0;
`endif
    endfunction

    function automatic logic [7:0] luma(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int s;
        s = 77 * int'(r) + 150 * int'(g) + 29 * int'(b);
        return 8'(s >> 8);
    endfunction

    // Source memory: data appears one cycle after the read strobe.
    logic [7:0] mem [0:65535];
    always @(posedge clk) src_data <= src_rd ? mem[src_addr] : 8'h00;

    // Converter model: constant latency per frame, 0..7 cycles.
    typedef struct { int due; logic [7:0] val; } conv_t;
    conv_t pend[$];
    int    lat = 1;
    initial begin
        int ccyc;
        ccyc = 0;
        conv_valid = 1'b0;
        gray = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            ccyc++;
            conv_valid = 1'b0;
            if (rst) begin
                pend.delete();
            end else begin
                if (pend.size() > 0 && pend[0].due == ccyc) begin
                    conv_valid = 1'b1;
                    gray = pend[0].val;
                    void'(pend.pop_front());
                end
                if (pix_valid) begin
                    if (lat == 0) begin
                        conv_valid = 1'b1;
                        gray = luma(red, green, blue);
                    end else begin
                        pend.push_back('{ccyc + lat, luma(red, green, blue)});
                    end
                end
            end
        end
    end

    logic [15:0] exp_addr[$];
    logic [23:0] exp_pix[$];
    logic [23:0] exp_wr[$];
    logic [15:0] exp_paddr[$];
    int cyc = 0, start_cyc = 0, last_wr_cyc = 0, done_cnt = 0, p_idx = 0;
    bit first_pix = 0;

    // Monitor: samples on the falling edge, pops expectations as the DUT presents them.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (start && !busy && !rst) begin
                start_cyc = cyc;
                first_pix = 1;
            end
            if (src_rd)
                check("rd_addr", 32'(src_addr), exp_addr.size() > 0 ? 32'(exp_addr.pop_front()) : 32'hDEAD_BEEF);
            if (pix_valid) begin
                check("pixel_rgb", 32'({red, green, blue}), exp_pix.size() > 0 ? 32'(exp_pix.pop_front()) : 32'hDEAD_BEEF);
                if (first_pix) begin
                    check("first_pix_latency", 32'(cyc - start_cyc), 32'd4);
                    first_pix = 0;
                end
            end
            if (dst_we) begin
                check("dst_write", 32'({dst_addr, dst_data}), exp_wr.size() > 0 ? 32'(exp_wr.pop_front()) : 32'hDEAD_BEEF);
                check("dst_data_is_gray", 32'(dst_data), 32'(gray));
                last_wr_cyc = cyc;
            end
            if (done) begin
                check("done_after_last_write", 32'(cyc - last_wr_cyc), 32'd1);
                check("writes_left_at_done", 32'(exp_wr.size()), 32'd0);
                done_cnt++;
            end
            if (p_rd) begin
                if (p_idx == 3 * PW)
                    check("row1_first_addr", 32'(p_addr), 32'(BASE + 3 * PW + pad_bytes(PW)));
                check("pad_rd_addr", 32'(p_addr), exp_paddr.size() > 0 ? 32'(exp_paddr.pop_front()) : 32'hDEAD_BEEF);
                p_idx++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic fill_random();
        for (int a = BASE; a < BASE + 128; a++) mem[a] = 8'($urandom);
    endtask

    // Queue the whole frame's expected reads, pixels and writes, then pulse start.
    task automatic start_frame();
        int a;
        logic [7:0] b, g, r;
        a = BASE;
        for (int p = 0; p < NPIX; p++) begin
            for (int k = 0; k < 3; k++) exp_addr.push_back(16'(a + k));
            b = mem[16'(a)];
            g = mem[16'(a + 1)];
            r = mem[16'(a + 2)];
            exp_pix.push_back({r, g, b});
            exp_wr.push_back({16'(p), luma(r, g, b)});
            a += 3;
            if ((p + 1) % W == 0) a += pad_bytes(W);
        end
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int target;
        target = done_cnt + 1;
        for (int i = 0; i < 400 && done_cnt < target; i++) step();
        check("frame_done_in_budget", 32'(done_cnt), 32'(target));
        check("err_clear_after_frame", 32'(err), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outputs"}, 32'({src_rd, pix_valid, dst_we, busy, done, err}), 32'd0);
        check({tag, "_addrs"}, 32'({src_addr, dst_addr}), 32'd0);
        check({tag, "_data"}, 32'({red, green, blue, dst_data}), 32'd0);
    endtask

    initial begin
        int a;
        rst = 1'b1; rst_p = 1'b1; start = 1'b0; start_p = 1'b0; inj_valid = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[BASE] = 8'h10; mem[BASE + 1] = 8'h02; mem[BASE + 2] = 8'h04;
        repeat (3) step();
        rst = 1'b0; rst_p = 1'b0;
        #1;
        check_all_zero("reset");

        // Padded-geometry instance: only its read address stream is checked.
        a = BASE;
        for (int r = 0; r < PH; r++) begin
            for (int k = 0; k < 3 * PW; k++) exp_paddr.push_back(16'(a + k));
            a += 3 * PW + pad_bytes(PW);
        end
        start_p = 1'b1;
        step();
        start_p = 1'b0;

        // Frame A: latency 1, fixed first pixel.
        lat = 1;
        start_frame();
        wait_done();

        // Frame B: latency 5, spurious start while reading.
        fill_random();
        lat = 5;
        start_frame();
        repeat (5) step();
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_ignored_start", 32'(busy), 32'd1);
        wait_done();

        // Frame C: random latency.
        fill_random();
        lat = $urandom_range(0, 7);
        start_frame();
        wait_done();

        // Frame D aborted by a 3-cycle reset mid-frame.
        fill_random();
        lat = 2;
        start_frame();
        repeat (8) step();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        exp_addr.delete(); exp_pix.delete(); exp_wr.delete();
        #1;
        check_all_zero("midframe_reset");

        // Frame E: restart after reset must read from the base address again.
        lat = 0;
        start_frame();
        wait_done();

        // Stray converter result in IDLE, then a start that clears the flag.
        inj_valid = 1'b1;
        #1;
        check("we_blocked_in_idle", 32'(dst_we), 32'd0);
        step();
        inj_valid = 1'b0;
        check("err_set_in_idle", 32'(err), 32'd1);
        fill_random();
        lat = $urandom_range(0, 7);
        start_frame();
        check("err_cleared_by_start", 32'(err), 32'd0);
        wait_done();

        repeat (4) step();
        check("reads_left", 32'(exp_addr.size()), 32'd0);
        check("pixels_left", 32'(exp_pix.size()), 32'd0);
        check("writes_left", 32'(exp_wr.size()), 32'd0);
        check("pad_reads_left", 32'(exp_paddr.size()), 32'd0);
        check("frames_done", 32'(done_cnt), 32'd5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/grayscale_frame_ctrl.md
GRAYSCALE_FRAME_CTRL -- requirements
Module: grayscale_frame_ctrl

Interface
REQ-001 Parameter IMG_W, default 128, image width in pixels (1..4095).
REQ-002 Parameter IMG_H, default 128, image height in pixels (1..4095).
REQ-003 Parameter SRC_BASE, default 54, byte address of the first pixel byte in the source memory.
REQ-004 Parameter ADDR_W, default 16, width of the source and destination address buses.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 Ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start_i  in  1  one-cycle frame start request.
- src_rd_o  out  1  source byte read strobe.
- src_addr_o  out  ADDR_W  source byte address.
- src_data_i  in  8  read data, valid 1 cycle after src_rd_o.
- red_o / green_o / blue_o  out  8 each  pixel to converter.
- pix_valid_o  out  1  pixel strobe to converter cam_done_i.
- gray_i  in  8  converter grayscale_o.
- gray_valid_i  in  1  converter done_o.
- dst_we_o  out  1  destination write enable.
- dst_addr_o  out  ADDR_W  destination pixel index.
- dst_data_o  out  8  destination write data.
- busy_o  out  1  frame in progress.
- done_o  out  1  one-cycle frame-complete pulse.
- err_o  out  1  sticky unexpected-result flag.

Function
REQ-007 The FSM SHALL have exactly four states: IDLE, READ, DRAIN, DONE.
REQ-008 IDLE:
- start_i=1 SHALL load src address=SRC_BASE, clear row, col and both pixel counters, clear err_o, and enter READ.
- busy_o SHALL be 0.
REQ-009 READ:
- src_rd_o=1 every cycle; src_addr_o SHALL increment by 1 per cycle.
- Byte lanes SHALL cycle 0=blue, 1=green, 2=red.
REQ-010 Packing: on the cycle the red byte returns, the block SHALL drive red_o/green_o/blue_o with the three returned bytes and pulse pix_valid_o for 1 cycle; sustained rate is one pixel per 3 cycles.
REQ-011 Col SHALL count 0..IMG_W-1; at wrap, row SHALL increment.
REQ-012 After the final byte read of pixel IMG_W*IMG_H-1, src_rd_o SHALL drop and the FSM SHALL enter DRAIN.
REQ-013 On each gray_valid_i=1 while busy and the write count is below IMG_W*IMG_H:
- dst_we_o=1, dst_data_o=gray_i, dst_addr_o=write count, all in the same cycle.
- The write count SHALL then increment.
- Results SHALL be accepted in READ and DRAIN, with any converter latency of 0..7 cycles.
REQ-014 When the write count reaches IMG_W*IMG_H, the FSM SHALL enter DONE, pulse done_o for 1 cycle, then return to IDLE.
REQ-015 gray_valid_i in IDLE or DONE, or beyond IMG_W*IMG_H writes, SHALL set err_o and SHALL NOT assert dst_we_o.
REQ-016 start_i outside IDLE SHALL be ignored.
REQ-017 busy_o SHALL be 1 in READ and DRAIN.
REQ-018 pix_valid_o and dst_we_o SHALL NOT assert outside READ/DRAIN.
REQ-019 Address arithmetic SHALL be ADDR_W-bit and wrap modulo 2^ADDR_W; no overflow detection.

Reset
REQ-020 rst=1 SHALL force IDLE and all outputs and counters to 0, regardless of state or other inputs, including mid-frame.
REQ-021 rst SHALL take priority over start_i in the same cycle.

Configuration
REQ-022 Macro GFC_ROW_PAD_EN:
- Defined: at each row end the source address SHALL skip PAD=(4-(3*IMG_W)%4)%4 bytes (BMP 4-byte row alignment) with no extra cycle.
- Undefined: rows are contiguous.

Structure
REQ-023 Package gfc_pkg SHALL hold:
- the state enum;
- byte-lane constants LANE_B=0, LANE_G=1, LANE_R=2;
- a function computing the row pad.
REQ-024 One sub-module, pixel_byte_packer, SHALL perform the 3-byte lane assembly and the pix_valid_o generation.

Verification
REQ-025 Reset: hold rst 3 cycles mid-frame -> next cycle all outputs 0, state IDLE; a new start_i then reads from address 54.
REQ-026 IMG_W=4, IMG_H=2, bytes 0x10,0x02,0x04 at 54..56 -> first pix_valid_o 4 cycles after start_i with red_o=0x04, green_o=0x02, blue_o=0x10; reads cover 54..77 contiguously.
REQ-027 Row pad, IMG_W=5, IMG_H=2 -> with GFC_ROW_PAD_EN, first row-1 read at address 70; without it, at 69.
REQ-028 Converter model latency 1, then 5 -> dst_addr_o 0..7 in order, dst_data_o equal to gray_i each write, done_o one cycle after the 8th write.
REQ-029 start_i during READ -> ignored, counters undisturbed.
REQ-030 gray_valid_i in IDLE -> err_o=1, dst_we_o=0; the next start_i clears err_o.
